// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, decode-stage control inputs,
// and the IF/ID bundle with the stack status flags.
interface fetch_stage_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_target;
    logic               push_ra;
    logic               pop_ra;
    logic [INSTR_W-1:0] id_instruction;
    logic [ADDR_W-1:0]  id_pc_plus1;
    logic               id_valid;
    logic               stack_overflow;
    logic               stack_underflow;

    // Fetch stage side
    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  redirect,
        input  redirect_target,
        input  push_ra,
        input  pop_ra,
        output id_instruction,
        output id_pc_plus1,
        output id_valid,
        output stack_overflow,
        output stack_underflow
    );

    // Memory / decode side
    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output redirect,
        output redirect_target,
        output push_ra,
        output pop_ra,
        input  id_instruction,
        input  id_pc_plus1,
        input  id_valid,
        input  stack_overflow,
        input  stack_underflow
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register: PC, next-PC selection and the
// hardware return-address stack for call/return.
module fetch_stage #(
    parameter int ADDR_W      = 12,
    parameter int INSTR_W     = 19,
    parameter int STACK_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    // IF state (p0) and IF/ID register (p1)
    logic [ADDR_W-1:0]  pc_p0;
    logic [INSTR_W-1:0] instr_p1;
    logic [ADDR_W-1:0]  pc_plus1_p1;
    logic               vld_p1;

    logic [SP_W-1:0]    sp;
    logic [ADDR_W-1:0]  ra_stack [STACK_DEPTH];
    logic               ovf_flag;
    logic               unf_flag;

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [SP_W-1:0]    sp_m1;
    logic [SP_W-1:0]    sp_nxt;
    logic [ADDR_W-1:0]  stack_top;
    logic               take;
    logic               stack_full;
    logic               stack_empty;
    logic               push_en;
    logic               ovf_set;
    logic               unf_set;

    // A redirect only counts when it comes from a real instruction in IF/ID
    assign take        = !bus.stall && bus.redirect && vld_p1;
    assign pc_inc      = pc_p0 + ADDR_W'(1);
    assign sp_m1       = sp - SP_W'(1);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign stack_top   = ra_stack[sp_m1[IDX_W-1:0]];

    // Next-PC and stack-pointer selection; push wins over pop
    always_comb begin
        pc_nxt  = pc_inc;
        sp_nxt  = sp;
        push_en = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (bus.stall) begin
            pc_nxt = pc_p0;
        end else if (take) begin
            if (bus.push_ra) begin
                pc_nxt = bus.redirect_target;
                if (!stack_full) begin
                    push_en = 1'b1;
                    sp_nxt  = sp + SP_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (bus.pop_ra) begin
                if (!stack_empty) begin
                    pc_nxt = stack_top;
                    sp_nxt = sp_m1;
                end else begin
                    pc_nxt  = '0;
                    unf_set = 1'b1;
                end
            end else begin
                pc_nxt = bus.redirect_target;
            end
        end
    end

    // PC, stack pointer and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0    <= '0;
            sp       <= '0;
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else begin
            pc_p0    <= pc_nxt;
            sp       <= sp_nxt;
            ovf_flag <= ovf_flag | ovf_set;
            unf_flag <= unf_flag | unf_set;
        end
    end

    // IF/ID register: hold on stall, flush to NOP on a taken redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_p1    <= '0;
            pc_plus1_p1 <= '0;
            vld_p1      <= 1'b0;
        end else if (!bus.stall) begin
            if (take) begin
                instr_p1    <= '0;
                pc_plus1_p1 <= '0;
                vld_p1      <= 1'b0;
            end else begin
                instr_p1    <= bus.imem_data;
                pc_plus1_p1 <= pc_inc;
                vld_p1      <= 1'b1;
            end
        end
    end

    // Return-address storage; contents are meaningless above sp so no reset
    always_ff @(posedge clk) begin
        if (push_en) begin
            ra_stack[sp[IDX_W-1:0]] <= pc_plus1_p1;
        end
    end

    assign bus.imem_addr       = pc_p0;
    assign bus.id_instruction  = instr_p1;
    assign bus.id_pc_plus1     = pc_plus1_p1;
    assign bus.id_valid        = vld_p1;
    assign bus.stack_overflow  = ovf_flag;
    assign bus.stack_underflow = unf_flag;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirect,
// call/return with stack overflow/underflow, PC wrap and async reset.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_stage_if #(.ADDR_W(12), .INSTR_W(19)) bus ();

    fetch_stage #(.ADDR_W(12), .INSTR_W(19), .STACK_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Address-tagged instruction memory
    function automatic logic [18:0] tag(input logic [11:0] a);
        return {7'h55, a};
    endfunction

    assign bus.imem_data = tag(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle control transfer request from decode
    task automatic xfer(input logic [11:0] tgt, input logic push, input logic pop);
        bus.redirect        = 1'b1;
        bus.redirect_target = tgt;
        bus.push_ra         = push;
        bus.pop_ra          = pop;
        step();
        bus.redirect        = 1'b0;
        bus.push_ra         = 1'b0;
        bus.pop_ra          = 1'b0;
    endtask

    task automatic check_id(input string name, input logic [11:0] pcp1, input logic [11:0] nxt_addr);
        check({name, "_valid"}, 32'(bus.id_valid), 32'd1);
        check({name, "_pcp1"}, 32'(bus.id_pc_plus1), 32'(pcp1));
        check({name, "_instr"}, 32'(bus.id_instruction), 32'(tag(pcp1 - 12'd1)));
        check({name, "_addr"}, 32'(bus.imem_addr), 32'(nxt_addr));
    endtask

    task automatic check_bubble(input string name, input logic [11:0] addr);
        check({name, "_valid"}, 32'(bus.id_valid), 32'd0);
        check({name, "_instr"}, 32'(bus.id_instruction), 32'd0);
        check({name, "_addr"}, 32'(bus.imem_addr), 32'(addr));
    endtask

    initial begin
        logic [11:0] exp_ra;
        bus.stall           = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        bus.push_ra         = 1'b0;
        bus.pop_ra          = 1'b0;

        // Reset state
        step();
        step();
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_valid", 32'(bus.id_valid), 32'd0);
        check("rst_pcp1", 32'(bus.id_pc_plus1), 32'd0);
        check("rst_instr", 32'(bus.id_instruction), 32'd0);
        check("rst_ovf", 32'(bus.stack_overflow), 32'd0);
        check("rst_unf", 32'(bus.stack_underflow), 32'd0);
        rst = 1'b0;

        // Free run: addresses 0..4 in order, no gaps
        for (int i = 1; i <= 5; i++) begin
            step();
            check_id($sformatf("run%0d", i), 12'(i), 12'(i));
        end

        // Stall three cycles at PC=5
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", 32'(bus.imem_addr), 32'h5);
            check("stall_pcp1", 32'(bus.id_pc_plus1), 32'h5);
            check("stall_instr", 32'(bus.id_instruction), 32'(tag(12'h4)));
        end
        bus.stall = 1'b0;
        step();
        check_id("unstall", 12'h6, 12'h6);

        // Plain jump: reach id_pc_plus1=0x011, then jump to 0x040
        xfer(12'h010, 1'b0, 1'b0);
        check_bubble("jmp10", 12'h010);
        step();
        check_id("at11", 12'h011, 12'h011);
        xfer(12'h040, 1'b0, 1'b0);
        check_bubble("jmp40", 12'h040);
        check("jmp40_pcp1", 32'(bus.id_pc_plus1), 32'd0);
        step();
        check_id("at41", 12'h041, 12'h041);

        // Call from id_pc_plus1=0x021 to 0x100, then return
        xfer(12'h020, 1'b0, 1'b0);
        step();
        check_id("at21", 12'h021, 12'h021);
        xfer(12'h100, 1'b1, 1'b0);
        check_bubble("call100", 12'h100);
        step();
        check_id("at101", 12'h101, 12'h101);
        step();
        xfer(12'h000, 1'b0, 1'b1);
        check_bubble("ret21", 12'h021);
        step();
        check_id("at22", 12'h022, 12'h022);
        check("ret_unf", 32'(bus.stack_underflow), 32'd0);

        // Nine nested calls; the ninth overflows
        for (int k = 0; k < 9; k++) begin
            xfer(12'h200 + 12'(k * 16), 1'b1, 1'b0);
            check_bubble($sformatf("ncall%0d", k), 12'h200 + 12'(k * 16));
            check($sformatf("ncall%0d_ovf", k), 32'(bus.stack_overflow), (k == 8) ? 32'd1 : 32'd0);
            step();
        end
        check_id("at281", 12'h281, 12'h281);

        // Eight returns unwind 0x261,0x251,...,0x201,0x022
        for (int j = 0; j < 8; j++) begin
            exp_ra = (j == 7) ? 12'h022 : 12'h201 + 12'((6 - j) * 16);
            xfer(12'h000, 1'b0, 1'b1);
            check_bubble($sformatf("nret%0d", j), exp_ra);
            check($sformatf("nret%0d_unf", j), 32'(bus.stack_underflow), 32'd0);
            step();
        end
        // Ninth return underflows to PC=0
        xfer(12'h7AB, 1'b0, 1'b1);
        check_bubble("nret_empty", 12'h000);
        check("nret_unf", 32'(bus.stack_underflow), 32'd1);
        check("nret_ovf_sticky", 32'(bus.stack_overflow), 32'd1);
        step();

        // PC wrap at 0xFFF
        xfer(12'hFFE, 1'b0, 1'b0);
        step();
        check_id("atFFF", 12'hFFF, 12'hFFF);
        step();
        check_id("wrap", 12'h000, 12'h000);

        // Redirect during stall is ignored
        bus.stall = 1'b1;
        xfer(12'h123, 1'b1, 1'b0);
        bus.stall = 1'b0;
        check_id("stall_redir", 12'h000, 12'h000);

        // Redirect while IF/ID holds a bubble is ignored
        xfer(12'h300, 1'b0, 1'b0);
        xfer(12'h500, 1'b0, 1'b0);
        check_id("bubble_redir", 12'h301, 12'h301);

        // Asynchronous reset in the middle of a redirect
        bus.redirect        = 1'b1;
        bus.redirect_target = 12'h555;
        #2;
        rst = 1'b1;
        #1;
        check("arst_addr", 32'(bus.imem_addr), 32'd0);
        check("arst_valid", 32'(bus.id_valid), 32'd0);
        check("arst_pcp1", 32'(bus.id_pc_plus1), 32'd0);
        check("arst_instr", 32'(bus.id_instruction), 32'd0);
        check("arst_ovf", 32'(bus.stack_overflow), 32'd0);
        check("arst_unf", 32'(bus.stack_underflow), 32'd0);
        bus.redirect = 1'b0;
        step();
        rst = 1'b0;
        step();
        check_id("post_rst", 12'h001, 12'h001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage (IF) plus IF/ID pipeline register for the 5-stage 8-bit processor.
- Owns the PC, next-PC selection and the hardware return-address stack used by call/return.
- Drives the instruction-memory address and presents a registered {instruction, PC+1, valid} bundle to the decode stage.
- Consumes stall and redirect requests resolved in decode.

Parameters:
ADDR_W, 12, PC / instruction-memory address width
INSTR_W, 19, instruction width
STACK_DEPTH, 8, return-address stack entries (power of two, ≥2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  ADDR_W  instruction-memory address (= PC)
imem_data  input  INSTR_W  instruction at imem_addr, combinational read
stall  input  1  hold PC and IF/ID register (decode hazard)
redirect  input  1  decode requests control transfer this cycle
redirect_target  input  ADDR_W  target for jump/branch/call
push_ra  input  1  with redirect: call, push id_pc_plus1
pop_ra  input  1  with redirect: return, target = stack top
id_instruction  output  INSTR_W  IF/ID instruction
id_pc_plus1  output  ADDR_W  IF/ID PC+1 of that instruction
id_valid  output  1  IF/ID holds a real instruction
stack_overflow  output  1  sticky: push attempted while full
stack_underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset (async, immediate) clears all of the following:
  - PC = 0, so imem_addr = 0.
  - id_instruction = 0 (NOP), id_pc_plus1 = 0, id_valid = 0.
  - Stack pointer sp = 0 (empty); stack contents need not be cleared.
  - stack_overflow = stack_underflow = 0.
- First valid instruction (address 0) appears on id_* one cycle after rst deasserts. Fetch latency: 1 cycle from PC to id_*.
- Registered outputs: imem_addr = PC, combinational from the PC register only. All id_* and flag outputs are registered.
- Per-cycle priority, evaluated at the rising edge:
  1. stall=1: PC, IF/ID, sp, stack and flags all hold. redirect/push/pop are ignored; decode reasserts them after the stall clears.
  2. stall=0, redirect=1, id_valid=1:
     - Flush: id_valid <= 0, id_instruction <= 0, id_pc_plus1 <= 0. The fetched imem_data is discarded.
     - push_ra=1 (call): PC <= redirect_target. If sp < STACK_DEPTH, stack[sp] <= id_pc_plus1 and sp <= sp+1. If full, the push is dropped, sp holds, stack_overflow <= 1.
     - pop_ra=1, push_ra=0 (return): if sp > 0, PC <= stack[sp-1] and sp <= sp-1. If empty, PC <= 0 and stack_underflow <= 1.
     - push_ra=0, pop_ra=0: PC <= redirect_target.
     - push_ra=1 and pop_ra=1 together: push wins, pop ignored.
  3. stall=0, redirect=1, id_valid=0: redirect/push/pop ignored (comes from a bubble); normal advance applies.
  4. Otherwise (normal advance): id_instruction <= imem_data, id_pc_plus1 <= PC+1, id_valid <= 1, PC <= PC+1.
- Arithmetic:
  - PC+1 is modulo 2^ADDR_W: 0xFFF -> 0x000, no flag.
  - sp is ceil(log2(STACK_DEPTH))+1 bits, range 0..STACK_DEPTH.
- Branch penalty: exactly one bubble per taken redirect. The instruction following the redirect target appears on id_* in the cycle after the bubble.
- Flags are sticky until reset. Overflow/underflow do not stall or halt fetch.
- Reset asserted mid-operation (including during a stall or redirect) overrides everything immediately.

Test Plan:
- Reset then free-run, imem_data = address-tagged pattern -> id_valid rises cycle 1. id_pc_plus1 sequence 1,2,3…; id_instruction matches addresses 0,1,2… with no gaps.
- stall=1 for 3 cycles at PC=5 -> imem_addr stays 5, id_* frozen (id_pc_plus1=5). After release, PC advances to 6 and id_pc_plus1=6 next.
- redirect to 0x040 while id_pc_plus1=0x011 (no stack op) -> next cycle id_valid=0, PC=0x040. Following cycle id_pc_plus1=0x041 with instruction from 0x040.
- Call at id_pc_plus1=0x021 to 0x100, later return -> stack holds 0x021, sp 1 -> 0. PC returns to 0x021. One bubble each transfer.
- 9 nested calls with STACK_DEPTH=8 -> stack_overflow=1 after 9th, sp=8. 8 returns restore correct addresses. 9th return -> PC=0, stack_underflow=1.
- PC at 0xFFF free-running -> id_pc_plus1=0x000, next imem_addr=0x000. redirect with stall=1 simultaneously -> ignored, state unchanged. rst pulse mid-redirect -> all outputs 0 asynchronously.
